// File: rtl/cmd_point_stack.sv
// cmd_point_stack
//   Command-driven address pointer with a hardware call/return stack.
//   Every accepted command (opcode != NUL while ready) updates the pointer and
//   the stack at the accepting edge. The block then spends exactly one BUSY
//   cycle with ready low. All outputs are registered, so opcode and addr_to
//   have no combinational path to any output.
//
// Parameters
//   BUS_WIDTH   width of addresses, addr_to and addr_point
//   STACK_DEPTH number of return-address entries (>= 1)
//   STEP        increment used by NXT and added to the return address by CAL
//
// Ports
//   clk         rising-edge clock
//   nreset      asynchronous active-low reset
//   opcode      3-bit command, sampled while ready=1
//   addr_to     jump target or unsigned relative offset
//   addr_point  current pointer
//   ready       high when a command can be accepted
//   stack_level number of occupied stack entries
//   overflow    one-cycle pulse: CAL rejected because the stack is full
//   underflow   one-cycle pulse: RET rejected because the stack is empty
//   illegal     one-cycle pulse: reserved opcode 111 accepted
module cmd_point_stack #(
   parameter int unsigned BUS_WIDTH   = 32,
   parameter int unsigned STACK_DEPTH = 8,
   parameter int unsigned STEP        = 1
) (
   input  logic                               clk,
   input  logic                               nreset,
   input  logic [2:0]                         opcode,
   input  logic [BUS_WIDTH-1:0]               addr_to,
   output logic [BUS_WIDTH-1:0]               addr_point,
   output logic                               ready,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
   output logic                               overflow,
   output logic                               underflow,
   output logic                               illegal
);

   localparam int unsigned LW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [BUS_WIDTH-1:0] STEP_W = BUS_WIDTH'(STEP);
   localparam logic [LW-1:0]        FULL_W = LW'(STACK_DEPTH);

   typedef enum logic {IDLE, BUSY} state_t;

   typedef enum logic [2:0] {
      OP_NUL = 3'b000,
      OP_JMP = 3'b001,
      OP_SJF = 3'b010,
      OP_NXT = 3'b011,
      OP_SJB = 3'b100,
      OP_CAL = 3'b101,
      OP_RET = 3'b110,
      OP_ILL = 3'b111
   } op_t;

   state_t                 state, state_nxt;
   logic                   accept;

   logic [BUS_WIDTH-1:0]   addr_nxt;
   logic [LW-1:0]          level_nxt;
   logic                   push;
   logic                   ovf_nxt, unf_nxt, ill_nxt;

   logic [BUS_WIDTH-1:0]   stack_mem [STACK_DEPTH];
   logic [AW-1:0]          push_idx, pop_idx;
   logic [BUS_WIDTH-1:0]   ret_addr;

   // The stack pointer is stack_level itself: push writes slot level, pop
   // reads slot level-1. Truncation is safe because a push never happens
   // when full and a pop never happens when empty.
   assign push_idx = AW'(stack_level);
   assign pop_idx  = AW'(stack_level - LW'(1));
   assign ret_addr = addr_point + STEP_W;

   assign ready = (state == IDLE);

   // FSM state register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state; BUSY always lasts exactly one cycle
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (opcode != OP_NUL) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command execution
   always_comb begin
      addr_nxt  = addr_point;
      level_nxt = stack_level;
      push      = 1'b0;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
      ill_nxt   = 1'b0;
      if (accept) begin
         case (opcode)
            OP_JMP: addr_nxt = addr_to;
            OP_SJF: addr_nxt = addr_point + addr_to;
            OP_SJB: addr_nxt = addr_point - addr_to;
            OP_NXT: addr_nxt = addr_point + STEP_W;
            OP_CAL: begin
               if (stack_level == FULL_W) begin
                  ovf_nxt = 1'b1;
               end else begin
                  push      = 1'b1;
                  level_nxt = stack_level + LW'(1);
                  addr_nxt  = addr_to;
               end
            end
            OP_RET: begin
               if (stack_level == '0) begin
                  unf_nxt = 1'b1;
               end else begin
                  level_nxt = stack_level - LW'(1);
                  addr_nxt  = stack_mem[pop_idx];
               end
            end
            OP_ILL:  ill_nxt = 1'b1;
            default: ;
         endcase
      end
   end

   // Pointer, level and pulses. Pulses clear on the BUSY edge because
   // accept is low there.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         addr_point  <= '0;
         stack_level <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         illegal     <= 1'b0;
      end else begin
         addr_point  <= addr_nxt;
         stack_level <= level_nxt;
         overflow    <= ovf_nxt;
         underflow   <= unf_nxt;
         illegal     <= ill_nxt;
      end
   end

   // Stack storage is not reset; only stack_level qualifies its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_mem[push_idx] <= ret_addr;
      end
   end

endmodule

// File: tb/tb_cmd_point_stack.sv
module tb_cmd_point_stack;

   logic        clk;
   logic        nreset;
   logic [2:0]  opcode;
   logic [31:0] addr_to;
   logic [31:0] addr_point;
   logic        ready;
   logic [3:0]  stack_level;
   logic        overflow, underflow, illegal;

   int checks   = 0;
   int failures = 0;
   bit done     = 0;

   cmd_point_stack #(
      .BUS_WIDTH(32),
      .STACK_DEPTH(8),
      .STEP(1)
   ) dut (
      .clk(clk),
      .nreset(nreset),
      .opcode(opcode),
      .addr_to(addr_to),
      .addr_point(addr_point),
      .ready(ready),
      .stack_level(stack_level),
      .overflow(overflow),
      .underflow(underflow),
      .illegal(illegal)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: pointer, queue-based stack, busy flag, pulses
   logic [31:0] m_addr;
   logic [31:0] m_stack[$];
   bit          m_busy, m_ovf, m_unf, m_ill;

   always @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         m_addr = 0; m_stack.delete();
         m_busy = 0; m_ovf = 0; m_unf = 0; m_ill = 0;
      end else if (m_busy) begin
         m_busy = 0; m_ovf = 0; m_unf = 0; m_ill = 0;
      end else if (opcode != 3'd0) begin
         m_busy = 1; m_ovf = 0; m_unf = 0; m_ill = 0;
         case (opcode)
            3'd1: m_addr = addr_to;
            3'd2: m_addr = m_addr + addr_to;
            3'd4: m_addr = m_addr - addr_to;
            3'd3: m_addr = m_addr + 32'd1;
            3'd5: if (m_stack.size() == 8) m_ovf = 1;
                  else begin m_stack.push_back(m_addr + 32'd1); m_addr = addr_to; end
            3'd6: if (m_stack.size() == 0) m_unf = 1;
                  else m_addr = m_stack.pop_back();
            default: m_ill = 1;
         endcase
      end
   end

   // Cycle-by-cycle compare against the model, half a period after each edge
   always @(negedge clk) begin
      if (!done) begin
         chk("m_addr",  addr_point, m_addr);
         chk("m_ready", 32'(ready), 32'(!m_busy));
         chk("m_level", 32'(stack_level), m_stack.size());
         chk("m_ovf",   32'(overflow), 32'(m_ovf));
         chk("m_unf",   32'(underflow), 32'(m_unf));
         chk("m_ill",   32'(illegal), 32'(m_ill));
      end
   end

   // Issue one command for one cycle; returns at the negedge inside BUSY
   task automatic cmd(input logic [2:0] op, input logic [31:0] a);
      @(negedge clk);
      opcode = op; addr_to = a;
      @(negedge clk);
      opcode = 3'd0; addr_to = 32'h0;
   endtask

   // Let the BUSY cycle finish
   task automatic idle();
      @(negedge clk);
   endtask

   logic [31:0] pushed [8];

   initial begin
      nreset = 0; opcode = 0; addr_to = 0;
      repeat (2) @(negedge clk);
      chk("rst_addr",  addr_point, 32'h0);
      chk("rst_ready", 32'(ready), 32'h1);
      chk("rst_level", 32'(stack_level), 32'h0);
      chk("rst_pulses", {29'h0, overflow, underflow, illegal}, 32'h0);
      nreset = 1;

      cmd(3'd1, 32'h1234);
      chk("jmp_addr", addr_point, 32'h1234);
      chk("jmp_busy", 32'(ready), 32'h0);
      idle();
      chk("jmp_ready", 32'(ready), 32'h1);

      cmd(3'd2, 32'd2); chk("sjf", addr_point, 32'h1236); idle();
      cmd(3'd4, 32'd2); chk("sjb", addr_point, 32'h1234); idle();
      cmd(3'd3, 32'd0); chk("nxt", addr_point, 32'h1235); idle();
      cmd(3'd1, 32'hFFFF_FFFF); idle();
      cmd(3'd3, 32'd0); chk("nxt_wrap", addr_point, 32'h0); idle();
      cmd(3'd4, 32'd1); chk("sjb_wrap", addr_point, 32'hFFFF_FFFF); idle();

      cmd(3'd1, 32'h100); idle();
      cmd(3'd5, 32'h200); chk("cal1_addr", addr_point, 32'h200);
      chk("cal1_lvl", 32'(stack_level), 32'd1); idle();
      cmd(3'd5, 32'h300); chk("cal2_lvl", 32'(stack_level), 32'd2); idle();
      cmd(3'd6, 32'h0); chk("ret1_addr", addr_point, 32'h201);
      chk("ret1_lvl", 32'(stack_level), 32'd1); idle();
      cmd(3'd6, 32'h0); chk("ret2_addr", addr_point, 32'h101);
      chk("ret2_lvl", 32'(stack_level), 32'd0); idle();

      // Fill the stack: CAL k jumps to 0x1000+(k+1)*0x10 and pushes its own address+1
      cmd(3'd1, 32'h1000); idle();
      for (int k = 0; k < 8; k++) begin
         pushed[k] = 32'h1000 + 32'(k) * 32'h10 + 32'h1;
         cmd(3'd5, 32'h1000 + 32'(k + 1) * 32'h10); idle();
      end
      chk("full_lvl", 32'(stack_level), 32'd8);
      cmd(3'd5, 32'h5000);
      chk("ovf_pulse", 32'(overflow), 32'h1);
      chk("ovf_addr", addr_point, 32'h1080);
      chk("ovf_lvl", 32'(stack_level), 32'd8);
      idle();
      chk("ovf_clear", 32'(overflow), 32'h0);
      for (int j = 0; j < 8; j++) begin
         cmd(3'd6, 32'h0);
         chk("ret_seq", addr_point, pushed[7 - j]);
         idle();
      end
      cmd(3'd6, 32'h0);
      chk("unf_pulse", 32'(underflow), 32'h1);
      chk("unf_addr", addr_point, 32'h1001);
      idle();
      chk("unf_clear", 32'(underflow), 32'h0);

      // JMP held for two cycles: second cycle falls in BUSY and is ignored
      @(negedge clk); opcode = 3'd1; addr_to = 32'h10;
      @(negedge clk); addr_to = 32'h10;
      @(negedge clk); opcode = 3'd0; addr_to = 32'h0;
      chk("hold_addr", addr_point, 32'h10);
      chk("hold_ready", 32'(ready), 32'h1);
      cmd(3'd2, 32'h0); idle();
      cmd(3'd7, 32'h999);
      chk("ill_pulse", 32'(illegal), 32'h1);
      chk("ill_addr", addr_point, 32'h10);
      chk("ill_busy", 32'(ready), 32'h0);
      idle();
      chk("ill_ready", 32'(ready), 32'h1);

      // Reset during BUSY with three entries on the stack
      for (int k = 0; k < 3; k++) begin cmd(3'd5, 32'h40); idle(); end
      chk("pre_rst_lvl", 32'(stack_level), 32'd3);
      @(negedge clk); opcode = 3'd3;
      @(posedge clk); #2;
      nreset = 0; opcode = 3'd0;
      #1;
      chk("mid_rst_addr", addr_point, 32'h0);
      chk("mid_rst_lvl", 32'(stack_level), 32'd0);
      chk("mid_rst_ready", 32'(ready), 32'h1);
      @(negedge clk); nreset = 1;
      cmd(3'd6, 32'h0);
      chk("post_rst_unf", 32'(underflow), 32'h1);
      chk("post_rst_addr", addr_point, 32'h0);
      idle();
      repeat (2) @(negedge clk);

      done = 1;
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
